leading_one_norm_pipe: RTL

- Parametrised, pipelined successor to the combinational divider leading-one detector.
- Finds the most-significant set bit of a WIDTH-bit mantissa and left-normalises it so the leading one sits at bit WIDTH-1.
- Reports the shift amount and an explicit zero flag.
- Elastic valid/ready stage between the divider/multiplier datapath and the rounding/pack stage of the multi-cycle FP unit.

---
 rtl/fp_norm_pkg.sv | 18 +
 rtl/leading_one_enc.sv | 25 ++
 rtl/leading_one_norm_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fp_norm_pkg.sv
// Shared defaults, result type and parameter sanity helper for the FP normalisation path.
package fp_norm_pkg;
  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int LOC_W  = 5;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [LOC_W-1:0]  loc;
    logic [LOC_W-1:0]  shift;
    logic              zero;
  } norm_result_t;

  // True when a loc_w-bit field can index every bit of a width-bit mantissa.
  function automatic bit loc_w_fits(input int width, input int loc_w);
    return ((longint'(1) << loc_w) >= longint'(width));
  endfunction
endpackage

// File: rtl/leading_one_enc.sv
// Combinational priority encoder: index of the highest set bit plus an all-zero flag.
module leading_one_enc
  import fp_norm_pkg::*;
#(
  parameter int WIDTH = fp_norm_pkg::MANT_W,
  parameter int LOC_W = fp_norm_pkg::LOC_W
) (
  input  logic [WIDTH-1:0] mant,
  output logic [LOC_W-1:0] loc,
  output logic             zero
);

  // Later (higher) set bits overwrite earlier ones, so the last hit wins.
  always_comb begin
    loc  = '0;
    zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (mant[i]) begin
        loc  = LOC_W'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/leading_one_norm_pipe.sv
// Two-stage elastic leading-one normaliser; define LEADING_ONE_NORM_EXP_EN to carry and adjust an exponent.
module leading_one_norm_pipe
  import fp_norm_pkg::*;
#(
  parameter int WIDTH = fp_norm_pkg::MANT_W,
  parameter int LOC_W = fp_norm_pkg::LOC_W,
  parameter int EXP_W = fp_norm_pkg::EXP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
`ifdef LEADING_ONE_NORM_EXP_EN
  input  logic [EXP_W-1:0] in_exp,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_uflow,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [LOC_W-1:0] out_msb_loc,
  output logic [LOC_W-1:0] out_shift,
  output logic             out_zero
);

  if (!loc_w_fits(WIDTH, LOC_W) || WIDTH < 2 || EXP_W < 1) begin : g_bad_params
    $error("leading_one_norm_pipe: illegal WIDTH/LOC_W/EXP_W combination");
  end

  logic             v1, v2;
  logic             ready1, ready2;
  logic [WIDTH-1:0] s1_mant, s2_mant;
  logic [LOC_W-1:0] s1_loc, s2_loc;
  logic [LOC_W-1:0] s1_shift, s2_shift;
  logic             s1_zero, s2_zero;
  logic [LOC_W-1:0] enc_loc;
  logic             enc_zero;
  logic [LOC_W-1:0] shift_in;

  assign ready2   = !v2 || out_ready;
  assign ready1   = !v1 || ready2;
  assign in_ready = ready1;

  leading_one_enc #(
    .WIDTH(WIDTH),
    .LOC_W(LOC_W)
  ) u_enc (
    .mant(in_mant),
    .loc (enc_loc),
    .zero(enc_zero)
  );

  // A zero mantissa is left unshifted so out_zero alone marks it.
  assign shift_in = enc_zero ? '0 : (LOC_W'(WIDTH - 1) - enc_loc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      s1_mant  <= '0;
      s1_loc   <= '0;
      s1_shift <= '0;
      s1_zero  <= 1'b0;
    end else begin
      if (ready1) v1 <= in_valid;
      if (in_valid && ready1) begin
        s1_mant  <= in_mant;
        s1_loc   <= enc_loc;
        s1_shift <= shift_in;
        s1_zero  <= enc_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2       <= 1'b0;
      s2_mant  <= '0;
      s2_loc   <= '0;
      s2_shift <= '0;
      s2_zero  <= 1'b0;
    end else begin
      if (ready2) v2 <= v1;
      if (v1 && ready2) begin
        s2_mant  <= s1_mant << s1_shift;
        s2_loc   <= s1_loc;
        s2_shift <= s1_shift;
        s2_zero  <= s1_zero;
      end
    end
  end

  assign out_valid   = v2;
  assign out_mant    = s2_mant;
  assign out_msb_loc = s2_loc;
  assign out_shift   = s2_shift;
  assign out_zero    = s2_zero;

`ifdef LEADING_ONE_NORM_EXP_EN
  localparam int DW = ((EXP_W > LOC_W) ? EXP_W : LOC_W) + 1;

  logic [EXP_W-1:0] s1_exp, s2_exp;
  logic             s2_uflow;
  logic [DW-1:0]    exp_diff;

  // The extra top bit of the difference is the borrow, i.e. in_exp < shift.
  assign exp_diff = DW'(s1_exp) - DW'(s1_shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_exp   <= '0;
      s2_exp   <= '0;
      s2_uflow <= 1'b0;
    end else begin
      if (in_valid && ready1) s1_exp <= in_exp;
      if (v1 && ready2) begin
        if (s1_zero || exp_diff[DW-1]) begin
          s2_exp   <= '0;
          s2_uflow <= !s1_zero && exp_diff[DW-1];
        end else begin
          s2_exp   <= exp_diff[EXP_W-1:0];
          s2_uflow <= 1'b0;
        end
      end
    end
  end

  assign out_exp   = s2_exp;
  assign out_uflow = s2_uflow;
`endif

endmodule
